// File: rtl/wb_stage_mc_if.sv
// MEM-to-WB bundle, regfile/HI/LO writeback and debug trace signals of the multi-lane WB stage.
interface wb_stage_mc_if #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0]       stall;
    logic [LANES-1:0]         mem_valid;
    logic [LANES*32-1:0]      mem_pc;
    logic [LANES-1:0]         mem_rf_we;
    logic [LANES*ADDR_W-1:0]  mem_rf_waddr;
    logic [LANES*DATA_W-1:0]  mem_rf_wdata;
    logic                     mem_hi_we;
    logic                     mem_lo_we;
    logic [DATA_W-1:0]        mem_hi;
    logic [DATA_W-1:0]        mem_lo;

    logic [LANES-1:0]         rf_we;
    logic [LANES*ADDR_W-1:0]  rf_waddr;
    logic [LANES*DATA_W-1:0]  rf_wdata;
    logic                     hi_we;
    logic                     lo_we;
    logic [DATA_W-1:0]        hi_o;
    logic [DATA_W-1:0]        lo_o;
    logic                     stallreq_wb;
    logic                     trace_ovf;
    logic [31:0]              debug_wb_pc;
    logic [3:0]               debug_wb_rf_wen;
    logic [ADDR_W-1:0]        debug_wb_rf_wnum;
    logic [DATA_W-1:0]        debug_wb_rf_wdata;

    modport slave (
        input  stall, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
               mem_hi_we, mem_lo_we, mem_hi, mem_lo,
        output rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi_o, lo_o, stallreq_wb,
               trace_ovf, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport master (
        output stall, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
               mem_hi_we, mem_lo_we, mem_hi, mem_lo,
        input  rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi_o, lo_o, stallreq_wb,
               trace_ovf, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage_mc.sv
// Multi-lane writeback stage: regfile/HI/LO valid 1 cycle after capture, trace head 1 cycle after push.
// Raises stallreq_wb when the trace FIFO cannot take a full bundle; excess pushes are dropped youngest first.
module wb_stage_mc #(
    parameter int LANES       = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int TRACE_DEPTH = 8,
    parameter int STALL_W     = 6
) (
    input  logic          clk,
    input  logic          rst,
    wb_stage_mc_if.slave  bus
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [LANES-1:0]        valid;
        logic [LANES*32-1:0]     pc;
        logic [LANES-1:0]        we;
        logic [LANES*ADDR_W-1:0] waddr;
        logic [LANES*DATA_W-1:0] wdata;
        logic                    hi_we;
        logic                    lo_we;
        logic [DATA_W-1:0]       hi;
        logic [DATA_W-1:0]       lo;
    } bundle_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } trace_t;

    bundle_t          bndl_q, bndl_d;
    logic             capture_w, bubble_w;
    logic [LANES-1:0] rf_we_w;

    trace_t           fifo_q [TRACE_DEPTH];
    trace_t           push_ent [LANES];
    logic [PW-1:0]    push_idx [LANES];
    logic [LANES-1:0] push_en;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, free_w, n_push;
    logic             pop_w, drop_w, ovf_q;
    trace_t           head_w;
    logic             empty_w;

    assign capture_w = ~bus.stall[4];
    assign bubble_w  = bus.stall[4] & ~bus.stall[5];

    always_comb begin
        bndl_d = bndl_q;
        if (bubble_w) begin
            bndl_d = '0;
        end else if (capture_w) begin
            bndl_d.valid = bus.mem_valid;
            bndl_d.pc    = bus.mem_pc;
            bndl_d.we    = bus.mem_rf_we;
            bndl_d.waddr = bus.mem_rf_waddr;
            bndl_d.wdata = bus.mem_rf_wdata;
            bndl_d.hi_we = bus.mem_hi_we;
            bndl_d.lo_we = bus.mem_lo_we;
            bndl_d.hi    = bus.mem_hi;
            bndl_d.lo    = bus.mem_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bndl_q <= '0;
        else      bndl_q <= bndl_d;
    end

    // A lane loses its write if any younger lane targets the same register.
    always_comb begin
        rf_we_w = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we_w[i] = bndl_q.valid[i] & bndl_q.we[i] &
                         (bndl_q.waddr[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (bndl_q.valid[j] && bndl_q.we[j] &&
                    bndl_q.waddr[j*ADDR_W +: ADDR_W] == bndl_q.waddr[i*ADDR_W +: ADDR_W])
                    rf_we_w[i] = 1'b0;
            end
        end
    end

    assign bus.rf_we    = rf_we_w;
    assign bus.rf_waddr = bndl_q.waddr;
    assign bus.rf_wdata = bndl_q.wdata;
    assign bus.hi_we    = bndl_q.hi_we & bndl_q.valid[0];
    assign bus.lo_we    = bndl_q.lo_we & bndl_q.valid[0];
    assign bus.hi_o     = bndl_q.valid[0] ? bndl_q.hi : '0;
    assign bus.lo_o     = bndl_q.valid[0] ? bndl_q.lo : '0;

    // Free space counts this cycle's pop, so a full FIFO still accepts one entry.
    always_comb begin
        pop_w   = (count_q != '0);
        free_w  = CW'(TRACE_DEPTH) - count_q + CW'(pop_w);
        n_push  = '0;
        drop_w  = 1'b0;
        push_en = '0;
        for (int i = 0; i < LANES; i++) begin
            push_ent[i].pc    = bus.mem_pc[i*32 +: 32];
            push_ent[i].we    = bus.mem_rf_we[i] & (bus.mem_rf_waddr[i*ADDR_W +: ADDR_W] != '0);
            push_ent[i].waddr = bus.mem_rf_waddr[i*ADDR_W +: ADDR_W];
            push_ent[i].wdata = bus.mem_rf_wdata[i*DATA_W +: DATA_W];
            push_idx[i]       = wr_ptr_q + n_push[PW-1:0];
            if (capture_w && bus.mem_valid[i]) begin
                if (n_push < free_w) begin
                    push_en[i] = 1'b1;
                    n_push     = n_push + CW'(1);
                end else begin
                    drop_w = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
        rd_ptr_d = rd_ptr_q + PW'(pop_w);
        count_d  = count_q + n_push - CW'(pop_w);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_en[i]) fifo_q[push_idx[i]] <= push_ent[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_q | drop_w;
        end
    end

    assign empty_w = (count_q == '0);
    assign head_w  = fifo_q[rd_ptr_q];

    assign bus.stallreq_wb       = (CW'(TRACE_DEPTH) - count_q) < CW'(LANES);
    assign bus.trace_ovf         = ovf_q;
    assign bus.debug_wb_pc       = empty_w ? '0 : head_w.pc;
    assign bus.debug_wb_rf_wen   = {4{head_w.we & ~empty_w}};
    assign bus.debug_wb_rf_wnum  = empty_w ? '0 : head_w.waddr;
    assign bus.debug_wb_rf_wdata = empty_w ? '0 : head_w.wdata;
endmodule
